node_output_arbiter: RTL and testbench
======================================

NODE_OUTPUT_ARBITER -- requirements
Module: node_output_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (input FIFOs) sharing the output port; fixed at 4 for this release.
REQ-002 Parameter DATA_WIDTH, default 16, flit width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  NUM_REQ  bit i high = requester i FIFO holds a flit.
REQ-006 req_data  input  NUM_REQ*DATA_WIDTH  head flit of requester i at bits [16i+15:16i].
REQ-007 req_tail  input  NUM_REQ  bit i high = head flit of requester i is a packet tail.
REQ-008 out_full  input  1  downstream buffer full; no flit may be forwarded while high.
REQ-009 pop  output  NUM_REQ  combinational, one-hot or zero; dequeues head flit of requester i this cycle.
REQ-010 sending_data  output  1  registered; data_out valid this cycle.
REQ-011 data_out  output  DATA_WIDTH  registered forwarded flit.
REQ-012 grant_id  output  2  registered index of requester that sourced data_out.
REQ-013 busy  output  1  registered; high while a packet lock is held.

Function
REQ-014 Grant condition in cycle N: out_full low and at least one eligible req bit high; otherwise pop = 0.
REQ-015 Winner = first eligible requester at or after priority pointer ptr, searching upward with wrap 3->0.
REQ-016 pop[winner] asserted combinationally in cycle N; no more than one pop bit ever high.
REQ-017 Latency 1: at edge ending cycle N, data_out <= req_data[winner], grant_id <= winner, sending_data <= 1.
REQ-018 Cycle with no grant: sending_data <= 0 at next edge; data_out and grant_id hold.
REQ-019 out_full high in cycle N: no pop, sending_data low in N+1, ptr and state unchanged.
REQ-020 Flit mode (macro absent): every requester eligible each cycle; ptr <= (winner+1) mod 4 after every grant.
REQ-021 ptr unchanged in cycles without a grant.
REQ-022 Simultaneous req on all four with out_full low forever: grants rotate strictly, each requester once per 4 cycles.
REQ-023 A requester whose req drops is skipped the same cycle; no bubble inserted for it.

Reset
REQ-024 rst high asynchronously forces: sending_data 0, data_out 0, grant_id 0, busy 0, ptr 0, state IDLE.
REQ-025 pop is 0 whenever rst is high.
REQ-026 Reset mid-packet abandons the lock; first grant after release uses ptr 0 and state IDLE.

Configuration
REQ-027 Macro ARB_PACKET_LOCK_EN, when defined, compiles in wormhole packet locking; absent, flit mode (REQ-020) only and busy tied 0.
REQ-028 With macro, state machine: IDLE, LOCKED; lock register holds owner index.
REQ-029 IDLE: all requesters eligible; grant of non-tail flit -> LOCKED, owner <= winner; grant of tail flit stays IDLE, ptr <= winner+1.
REQ-030 LOCKED: only owner eligible; owner req low or out_full high -> no pop, stay LOCKED (bubble).
REQ-031 LOCKED: pop of owner tail flit -> IDLE, ptr <= (owner+1) mod 4; busy low from next cycle.
REQ-032 busy registered high in every cycle following entry to LOCKED until the cycle after the tail pop.

Verification
REQ-033 Reset release, req=1111, out_full=0, all tails=1 -> pop 0001,0010,0100,1000,0001; grant_id 0,1,2,3,0 one cycle later.
REQ-034 req=0101, req_data0=16'hAAAA, req_data2=16'h5555, out_full high 3 cycles then low -> no pop for 3 cycles, then pop 0001, data_out=AAAA next cycle, then pop 0100.
REQ-035 Lock mode: requester 1 sends 3-flit packet (tail on third) while req=1111 -> pop 0010 three times (with a bubble if req1 drops), busy high throughout, next grant to requester 2.
REQ-036 Lock mode: rst pulsed during LOCKED by requester 3 -> busy 0, sending_data 0 immediately; next grant to requester 0.
REQ-037 Flit mode: req=1000 only, 4 cycles -> pop 1000 each cycle, sending_data high continuously, ptr wraps to 0.

Source files
------------

// File: rtl/node_output_arbiter_if.sv
// node_output_arbiter_if: request/flit bus between input FIFOs, output arbiter and downstream port
interface node_output_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_tail;
    logic                          out_full;
    logic [NUM_REQ-1:0]            pop;
    logic                          sending_data;
    logic [DATA_WIDTH-1:0]         data_out;
    logic [$clog2(NUM_REQ)-1:0]    grant_id;
    logic                          busy;

    modport master (
        output req, req_data, req_tail, out_full,
        input  pop, sending_data, data_out, grant_id, busy
    );

    modport slave (
        input  req, req_data, req_tail, out_full,
        output pop, sending_data, data_out, grant_id, busy
    );
endinterface

// File: rtl/node_output_arbiter.sv
// node_output_arbiter: round-robin output port arbiter; ARB_PACKET_LOCK_EN adds wormhole packet locking
module node_output_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
) (
    input logic            clk,
    input logic            rst,
    node_output_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]         ptr, ptr_next, winner, idx;
    logic [NUM_REQ-1:0]    eligible;
    logic [DATA_WIDTH-1:0] flit [NUM_REQ];
    logic                  found, grant, release_ptr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign flit[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef ARB_PACKET_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state, state_next;
    logic [IW-1:0] owner, owner_next;

    // lock state and owner register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    // a locked port only listens to the owner; everyone competes when idle
    assign eligible = (state == LOCKED) ? (bus.req & (NUM_REQ'(1) << owner)) : bus.req;

    // non-tail grant from idle takes the lock, any tail grant drops it and advances the pointer
    always_comb begin
        state_next  = state;
        owner_next  = owner;
        release_ptr = 1'b0;
        if (grant) begin
            if (bus.req_tail[winner]) begin
                state_next  = IDLE;
                release_ptr = 1'b1;
            end else if (state == IDLE) begin
                state_next = LOCKED;
                owner_next = winner;
            end
        end
    end

    assign bus.busy = (state == LOCKED);
`else
    logic unused_tail;

    assign unused_tail = ^bus.req_tail;
    assign eligible    = bus.req;
    assign release_ptr = grant;
    assign bus.busy    = 1'b0;
`endif

    // first eligible requester at or after ptr, wrapping upward
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + IW'(i);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign grant    = found & ~bus.out_full & ~rst;
    assign bus.pop  = grant ? (NUM_REQ'(1) << winner) : '0;
    assign ptr_next = release_ptr ? winner + IW'(1) : ptr;

    // priority pointer only moves when a flit grant completes a packet (every grant in flit mode)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else     ptr <= ptr_next;
    end

    // forwarded flit registers; data and id hold across idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sending_data <= 1'b0;
            bus.data_out     <= '0;
            bus.grant_id     <= '0;
        end else begin
            bus.sending_data <= grant;
            if (grant) begin
                bus.data_out <= flit[winner];
                bus.grant_id <= winner;
            end
        end
    end
endmodule

// File: tb/tb_node_output_arbiter.sv
// tb_node_output_arbiter: directed and random checks of the output arbiter against a reference model
module tb_node_output_arbiter;
    localparam int N = 4;
    localparam int W = 16;
`ifdef ARB_PACKET_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    node_output_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();
    node_output_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int            m_ptr, m_owner, e_win;
    bit            m_locked;
    logic [W-1:0]  e_data;
    logic [1:0]    e_gid;
    logic          e_send, e_busy;
    logic [N-1:0]  e_pop, last_pop;
    logic [N*W-1:0] rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_pop(input logic [N-1:0] r, input logic full);
        e_win = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (e_win < 0 && r[c] && (!m_locked || c == m_owner)) e_win = c;
        end
        if (full) e_win = -1;
        e_pop = (e_win < 0) ? '0 : N'(1 << e_win);
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] t, input logic full, input logic [N*W-1:0] d);
        @(negedge clk);
        bus.req      = r;
        bus.req_tail = t;
        bus.out_full = full;
        bus.req_data = d;
        #1;
        model_pop(r, full);
        last_pop = bus.pop;
        chk("pop", bus.pop, e_pop);
        @(posedge clk);
        #1;
        e_send = (e_win >= 0);
        if (e_win >= 0) begin
            e_data = d[e_win*W +: W];
            e_gid  = 2'(e_win);
            if (LOCK && !t[e_win]) begin
                m_locked = 1'b1;
                m_owner  = e_win;
            end else begin
                m_locked = 1'b0;
                m_ptr    = (e_win + 1) % N;
            end
        end
        e_busy = m_locked;
        chk("sending_data", bus.sending_data, e_send);
        chk("data_out", bus.data_out, e_data);
        chk("grant_id", bus.grant_id, e_gid);
        chk("busy", bus.busy, e_busy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_sending", bus.sending_data, 1'b0);
        chk("rst_data", bus.data_out, '0);
        chk("rst_gid", bus.grant_id, '0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_pop", bus.pop, '0);
        @(posedge clk);
        #1;
        chk("rst_pop_edge", bus.pop, '0);
        @(negedge clk);
        bus.req      = '0;
        bus.out_full = 1'b0;
        rst          = 1'b0;
        m_ptr    = 0;
        m_locked = 1'b0;
        m_owner  = 0;
        e_send   = 1'b0;
        e_data   = '0;
        e_gid    = '0;
        e_busy   = 1'b0;
    endtask

    initial begin
        bus.req      = '0;
        bus.req_tail = '0;
        bus.out_full = 1'b0;
        bus.req_data = '0;
        rst          = 1'b1;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            logic [N-1:0] exp_rot [5];
            exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            step(4'b1111, 4'b1111, 1'b0, {16'h3333, 16'h2222, 16'h1111, 16'h0000});
            chk("rotate_pop", last_pop, exp_rot[i]);
        end

        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(4'b0101, 4'b1111, 1'b1, {16'h0, 16'h5555, 16'h0, 16'hAAAA});
            chk("full_no_pop", last_pop, '0);
        end
        step(4'b0101, 4'b1111, 1'b0, {16'h0, 16'h5555, 16'h0, 16'hAAAA});
        chk("full_release_pop", last_pop, 4'b0001);
        chk("full_release_data", bus.data_out, 16'hAAAA);
        step(4'b0101, 4'b1111, 1'b0, {16'h0, 16'h5555, 16'h0, 16'hAAAA});
        chk("full_next_pop", last_pop, 4'b0100);
        chk("full_next_data", bus.data_out, 16'h5555);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(4'b1000, 4'b1111, 1'b0, {16'hBEE0 + 16'(i), 48'h0});
            chk("single_pop", last_pop, 4'b1000);
            chk("single_send", bus.sending_data, 1'b1);
        end
        step(4'b1111, 4'b1111, 1'b0, 64'h0004_0003_0002_0001);
        chk("single_wrap_pop", last_pop, 4'b0001);

`ifdef ARB_PACKET_LOCK_EN
        do_reset();
        step(4'b1111, 4'b1111, 1'b0, 64'h0);
        step(4'b1111, 4'b0000, 1'b0, 64'h0000_0000_0A01_0000);
        chk("lock_first", last_pop, 4'b0010);
        chk("lock_busy1", bus.busy, 1'b1);
        step(4'b1111, 4'b0000, 1'b0, 64'h0000_0000_0A02_0000);
        chk("lock_second", last_pop, 4'b0010);
        step(4'b1101, 4'b0000, 1'b0, 64'h0);
        chk("lock_bubble", last_pop, '0);
        chk("lock_busy_bubble", bus.busy, 1'b1);
        step(4'b1111, 4'b0010, 1'b0, 64'h0000_0000_0A03_0000);
        chk("lock_tail", last_pop, 4'b0010);
        chk("lock_busy_after", bus.busy, 1'b0);
        step(4'b1111, 4'b1111, 1'b0, 64'h0);
        chk("lock_next", last_pop, 4'b0100);

        do_reset();
        step(4'b1000, 4'b0000, 1'b0, 64'h7777_0000_0000_0000);
        step(4'b1111, 4'b0000, 1'b0, 64'h7778_0000_0000_0000);
        chk("lock3_busy", bus.busy, 1'b1);
        do_reset();
        step(4'b1111, 4'b1111, 1'b0, 64'h0);
        chk("lock_reset_next", last_pop, 4'b0001);
`endif

        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r, t;
            r  = N'($urandom);
            t  = LOCK ? (N'($urandom) & N'($urandom)) : N'($urandom);
            rd = {$urandom(), $urandom()};
            step(r, t, ($urandom_range(0, 3) == 0), rd);
            if (i == 200) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
